// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with shifts, compares and iterative unsigned multiply/divide
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             zout,
  output logic             vout,
  output logic             sout,
  output logic             dzout
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  // opa holds the multiplicand or the divisor for the whole iteration
  logic [WIDTH-1:0] opa_q, opa_d;
  // acc_hi/acc_lo: product high/low halves, or remainder/quotient
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] hi_out_q, hi_out_d;
  logic             zout_q, zout_d;
  logic             vout_q, vout_d;
  logic             sout_q, sout_d;
  logic             dzout_q, dzout_d;

  logic [WIDTH-1:0] sc_alu;
  logic             sc_v;
  logic [WIDTH-1:0] add_res, sub_res;
  logic             add_v, sub_v;
  logic [SHW-1:0]   shamt;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_sh, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  logic             load_out;
  logic [WIDTH-1:0] res_alu, res_hi;
  logic             res_v, res_dz;

  // Single-cycle result from the live operands; sampled only on the start edge
  always_comb begin
    add_res = a + b;
    sub_res = a + ~b + 1'b1;
    add_v   = (a[MSB] == b[MSB]) && (add_res[MSB] != a[MSB]);
    sub_v   = (a[MSB] != b[MSB]) && (sub_res[MSB] != a[MSB]);
    shamt   = b[SHW-1:0];
    sc_alu  = '0;
    sc_v    = 1'b0;
    case (alu_control)
      OP_AND:  sc_alu = a & b;
      OP_OR:   sc_alu = a | b;
      OP_ADD:  begin sc_alu = add_res; sc_v = add_v; end
      OP_XOR:  sc_alu = a ^ b;
      OP_NOR:  sc_alu = ~(a | b);
      OP_SUB:  begin sc_alu = sub_res; sc_v = sub_v; end
      // Sign of the difference corrected by overflow gives the true signed order
      OP_SLT:  sc_alu = {{(WIDTH-1){1'b0}}, sub_res[MSB] ^ sub_v};
      OP_SLTU: sc_alu = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_alu = a << shamt;
      OP_SRL:  sc_alu = a >> shamt;
      OP_SRA:  sc_alu = WIDTH'($signed(a) >>> shamt);
      default: sc_alu = '0;
    endcase
  end

  // One iteration of shift-add multiply and of restoring division
  always_comb begin
    mul_sum   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opa_q}) : {1'b0, acc_hi_q};
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_sh - {1'b0, opa_q};
    div_ge    = ~div_diff[WIDTH];
    rem_nx    = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    quo_nx    = {acc_lo_q[WIDTH-2:0], div_ge};
  end

  // Next-state logic and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    load_out = 1'b0;
    res_alu  = '0;
    res_hi   = '0;
    res_v    = 1'b0;
    res_dz   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (alu_control == OP_MULU) begin
            opa_d    = a;
            acc_hi_d = '0;
            acc_lo_d = b;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else if (alu_control == OP_DIVU) begin
            if (b == '0) begin
              load_out = 1'b1;
              res_alu  = '1;
              res_hi   = a;
              res_dz   = 1'b1;
              state_d  = S_DONE;
            end else begin
              opa_d    = b;
              acc_hi_d = '0;
              acc_lo_d = a;
              cnt_d    = '0;
              state_d  = S_DIV;
            end
          end else begin
            load_out = 1'b1;
            res_alu  = sc_alu;
            res_v    = sc_v;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_hi_d = mul_hi_nx;
        acc_lo_d = mul_lo_nx;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          load_out = 1'b1;
          res_alu  = mul_lo_nx;
          res_hi   = mul_hi_nx;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_hi_d = rem_nx;
        acc_lo_d = quo_nx;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          load_out = 1'b1;
          res_alu  = quo_nx;
          res_hi   = rem_nx;
          state_d  = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and flags update only on the edge that raises done
  always_comb begin
    alu_out_d = alu_out_q;
    hi_out_d  = hi_out_q;
    zout_d    = zout_q;
    vout_d    = vout_q;
    sout_d    = sout_q;
    dzout_d   = dzout_q;
    if (load_out) begin
      alu_out_d = res_alu;
      hi_out_d  = res_hi;
      zout_d    = ~|res_alu;
      vout_d    = res_v;
      sout_d    = res_alu[MSB];
      dzout_d   = res_dz;
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      opa_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      alu_out_q <= '0;
      hi_out_q  <= '0;
      zout_q    <= 1'b0;
      vout_q    <= 1'b0;
      sout_q    <= 1'b0;
      dzout_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opa_q     <= opa_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      alu_out_q <= alu_out_d;
      hi_out_q  <= hi_out_d;
      zout_q    <= zout_d;
      vout_q    <= vout_d;
      sout_q    <= sout_d;
      dzout_q   <= dzout_d;
    end
  end

  assign busy    = (state_q == S_MUL) || (state_q == S_DIV);
  assign done    = (state_q == S_DONE);
  assign alu_out = alu_out_q;
  assign hi_out  = hi_out_q;
  assign zout    = zout_q;
  assign vout    = vout_q;
  assign sout    = sout_q;
  assign dzout   = dzout_q;

endmodule
